// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
package dmem_pkg;

   localparam int DATA_W    = 16;
   localparam int DEF_DEPTH = 1024;
   localparam int DEF_AW    = 10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_e;

   // A request is bad if it is not halfword aligned or its word index lands
   // past the last stored word; any address bit above the index field pushes
   // the index past 2**AW, so one compare covers both range cases.
   function automatic logic addr_err(input logic [DATA_W-1:0] addr, input int depth);
      logic [31:0] widx;
      widx = 32'(addr >> 1);
      return addr[0] || (widx >= 32'(depth));
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between CPU and data memory.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request and the response channel.
interface dmem_responder_if;
   import dmem_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [DATA_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with a registered read port.
// Latency: read data valid the cycle after an enabled load; store lands on the same edge.
// Backpressure: none; the caller decides when to enable it.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = DEF_AW
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [AW-1:0]     idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Store writes the word; load captures it into the output register, which then holds.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem_q[idx] <= wdata;
         end else begin
            rdata_q <= mem_q[idx];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed wait, then a held response.
// Latency: rsp_valid rises WAIT_CYCLES+1 cycles after the accepting edge.
// Backpressure: response held stable until rsp_ready; req_ready low from accept to response taken.
// Optional: define DMEM_STATS_EN to add the stat_loads/stat_stores/stat_errs counters.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH       = DEF_DEPTH,
   parameter int AW          = DEF_AW,
   parameter int WAIT_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   dmem_responder_if.slave    bus
`ifdef DMEM_STATS_EN
   ,
   output logic [DATA_W-1:0]  stat_loads,
   output logic [DATA_W-1:0]  stat_stores,
   output logic [DATA_W-1:0]  stat_errs
`endif
);

   localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              err_q, err_d;
   logic              enter_resp;

   logic              op_we;
   logic [DATA_W-1:0] op_addr;
   logic [DATA_W-1:0] op_wdata;
   logic              op_err;
   logic [DATA_W-1:0] ram_rdata;

   // Operation seen by the RAM on the edge entering RESP: the live bus when
   // leaving IDLE directly (zero wait), otherwise the latched request.
   always_comb begin
      op_we    = we_q;
      op_addr  = addr_q;
      op_wdata = wdata_q;
      if (state_q == IDLE) begin
         op_we    = bus.req_we;
         op_addr  = bus.req_addr;
         op_wdata = bus.req_wdata;
      end
      op_err = addr_err(op_addr, DEPTH);
   end

   // Next state, request latch, wait countdown and error capture.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      enter_resp = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               if (WAIT_CYCLES == 0) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d    = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (enter_resp) begin
         err_d = op_err;
      end
   end

   // FSM and request registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end

   // Errored requests never touch the array, so a bad store cannot corrupt memory.
   dmem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .en    (enter_resp & ~op_err),
      .we    (op_we),
      .idx   (op_addr[AW:1]),
      .wdata (op_wdata),
      .rdata (ram_rdata)
   );

   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_err   = (state_q == RESP) & err_q;
   assign bus.rsp_rdata = ((state_q == RESP) && !we_q && !err_q) ? ram_rdata : '0;

`ifdef DMEM_STATS_EN
   logic              rsp_hs;
   logic [DATA_W-1:0] loads_q, loads_d;
   logic [DATA_W-1:0] stores_q, stores_d;
   logic [DATA_W-1:0] errs_q, errs_d;

   assign rsp_hs = (state_q == RESP) & bus.rsp_ready;

   // Tally each taken response; an errored one counts only as an error. Counters wrap.
   always_comb begin
      loads_d  = loads_q;
      stores_d = stores_q;
      errs_d   = errs_q;
      if (rsp_hs) begin
         if (err_q) begin
            errs_d = errs_q + 16'd1;
         end else if (we_q) begin
            stores_d = stores_q + 16'd1;
         end else begin
            loads_d = loads_q + 16'd1;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loads_q  <= '0;
         stores_q <= '0;
         errs_q   <= '0;
      end else begin
         loads_q  <= loads_d;
         stores_q <= stores_d;
         errs_q   <= errs_d;
      end
   end

   assign stat_loads  = loads_q;
   assign stat_stores = stores_q;
   assign stat_errs   = errs_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: scoreboard of expected responses, latency,
// hold-under-backpressure, error and reset-mid-wait checks; a second instance
// with WAIT_CYCLES=0 covers the zero-wait path.
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int WAIT_A = 2;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   // Shared request drive; sel picks which instance sees it.
   logic        sel;
   logic        req_valid;
   logic        req_we;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        rsp_ready;

   logic        c_req_ready;
   logic        c_rsp_valid;
   logic [15:0] c_rsp_rdata;
   logic        c_rsp_err;

   logic [16:0] sb_q[$];

   dmem_responder_if bus();
   dmem_responder_if bus0();

`ifdef DMEM_STATS_EN
   logic [15:0] stat_loads, stat_stores, stat_errs;
   logic [15:0] z_loads, z_stores, z_errs;
`endif

   dmem_responder #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(WAIT_A)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef DMEM_STATS_EN
      ,
      .stat_loads  (stat_loads),
      .stat_stores (stat_stores),
      .stat_errs   (stat_errs)
`endif
   );

   dmem_responder #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
`ifdef DMEM_STATS_EN
      ,
      .stat_loads  (z_loads),
      .stat_stores (z_stores),
      .stat_errs   (z_errs)
`endif
   );

   assign bus.req_valid  = req_valid & ~sel;
   assign bus.req_we     = req_we;
   assign bus.req_addr   = req_addr;
   assign bus.req_wdata  = req_wdata;
   assign bus.rsp_ready  = rsp_ready & ~sel;
   assign bus0.req_valid = req_valid & sel;
   assign bus0.req_we    = req_we;
   assign bus0.req_addr  = req_addr;
   assign bus0.req_wdata = req_wdata;
   assign bus0.rsp_ready = rsp_ready & sel;

   assign c_req_ready = sel ? bus0.req_ready : bus.req_ready;
   assign c_rsp_valid = sel ? bus0.rsp_valid : bus.rsp_valid;
   assign c_rsp_rdata = sel ? bus0.rsp_rdata : bus.rsp_rdata;
   assign c_rsp_err   = sel ? bus0.rsp_err   : bus.rsp_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete transaction, entered and left at #1 after a rising edge.
   task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input int hold, input logic [15:0] exp_rd, input logic exp_err,
                         input string tag);
      int          n;
      int          exp_lat;
      logic [16:0] exp;
      logic [15:0] rd0;
      logic        er0;
      exp_lat = sel ? 1 : 1 + WAIT_A;
      sb_q.push_back({exp_err, exp_rd});
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_valid = 1'b1;
      n = 0;
      while (!c_req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_ready"}, 32'(c_req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 1;
      while (!c_rsp_valid && n < 40) begin
         check({tag, "_busy"}, 32'(c_req_ready), 32'd0);
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_lat"}, 32'(n), 32'(exp_lat));
      rd0 = c_rsp_rdata;
      er0 = c_rsp_err;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, "_hold_vld"}, 32'(c_rsp_valid), 32'd1);
         check({tag, "_hold_rd"}, 32'(c_rsp_rdata), 32'(rd0));
         check({tag, "_hold_err"}, 32'(c_rsp_err), 32'(er0));
         check({tag, "_hold_rdy"}, 32'(c_req_ready), 32'd0);
      end
      check({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
         exp = sb_q.pop_front();
         check({tag, "_rdata"}, 32'(c_rsp_rdata), 32'(exp[15:0]));
         check({tag, "_err"}, 32'(c_rsp_err), 32'(exp[16]));
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check({tag, "_taken"}, 32'(c_rsp_valid), 32'd0);
      check({tag, "_idle"}, 32'(c_req_ready), 32'd1);
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      sel       = 1'b0;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b0;

      // Reset values.
      #12;
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
      check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Store then load back.
      do_req(1'b1, 16'h0000, 16'h0005, 0, 16'h0000, 1'b0, "st0");
      do_req(1'b0, 16'h0000, 16'h0000, 0, 16'h0005, 1'b0, "ld0");

      // Back-to-back stores and loads.
      do_req(1'b1, 16'h0002, 16'h0007, 0, 16'h0000, 1'b0, "st2");
      do_req(1'b1, 16'h0004, 16'hBEEF, 0, 16'h0000, 1'b0, "st4");
      do_req(1'b0, 16'h0002, 16'h0000, 0, 16'h0007, 1'b0, "ld2");
      do_req(1'b0, 16'h0004, 16'h0000, 0, 16'hBEEF, 1'b0, "ld4");

      // Response held for five cycles under backpressure.
      do_req(1'b1, 16'h0008, 16'h1234, 0, 16'h0000, 1'b0, "st8");
      do_req(1'b0, 16'h0008, 16'h0000, 5, 16'h1234, 1'b0, "ld8_bp");

      // Error cases; words 0 and 1 must be untouched.
      do_req(1'b1, 16'h0003, 16'h9999, 0, 16'h0000, 1'b1, "st_mis");
      do_req(1'b1, 16'h0800, 16'h8888, 0, 16'h0000, 1'b1, "st_oor");
      do_req(1'b0, 16'h0002, 16'h0000, 0, 16'h0007, 1'b0, "ld_w1_keep");
      do_req(1'b0, 16'h0000, 16'h0000, 0, 16'h0005, 1'b0, "ld_w0_keep");
      do_req(1'b0, 16'h0801, 16'h0000, 0, 16'h0000, 1'b1, "ld_err");
      do_req(1'b0, 16'h8000, 16'h0000, 0, 16'h0000, 1'b1, "ld_hibit");

      // Last valid word.
      do_req(1'b1, 16'h07FE, 16'h7777, 0, 16'h0000, 1'b0, "st_last");
      do_req(1'b0, 16'h07FE, 16'h0000, 0, 16'h7777, 1'b0, "ld_last");

      // Reset while a store sits in WAIT: store is dropped.
      do_req(1'b1, 16'h0006, 16'h1111, 0, 16'h0000, 1'b0, "st6_old");
      req_we    = 1'b1;
      req_addr  = 16'h0006;
      req_wdata = 16'hAAAA;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("midwait_busy", 32'(bus.req_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("midwait_rst_ready", 32'(bus.req_ready), 32'd1);
      check("midwait_rst_valid", 32'(bus.rsp_valid), 32'd0);
      check("midwait_rst_rdata", 32'(bus.rsp_rdata), 32'd0);
      check("midwait_rst_err",   32'(bus.rsp_err),   32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
`ifdef DMEM_STATS_EN
      check("stat_rst_loads",  32'(stat_loads),  32'd0);
      check("stat_rst_stores", 32'(stat_stores), 32'd0);
      check("stat_rst_errs",   32'(stat_errs),   32'd0);
`endif

      // After reset: three loads, two stores, one errored load.
      do_req(1'b0, 16'h0006, 16'h0000, 0, 16'h1111, 1'b0, "ld6_old");
      do_req(1'b0, 16'h0008, 16'h0000, 0, 16'h1234, 1'b0, "ld8_again");
      do_req(1'b1, 16'h000A, 16'hA5A5, 0, 16'h0000, 1'b0, "st10");
      do_req(1'b1, 16'h000C, 16'h5A5A, 0, 16'h0000, 1'b0, "st12");
      do_req(1'b0, 16'h000A, 16'h0000, 0, 16'hA5A5, 1'b0, "ld10");
      do_req(1'b0, 16'h0801, 16'h0000, 0, 16'h0000, 1'b1, "ld_err2");
`ifdef DMEM_STATS_EN
      check("stat_loads",  32'(stat_loads),  32'd3);
      check("stat_stores", 32'(stat_stores), 32'd2);
      check("stat_errs",   32'(stat_errs),   32'd1);
`endif

      // Zero-wait instance.
      sel = 1'b1;
      @(posedge clk); #1;
      do_req(1'b1, 16'h0014, 16'h4321, 0, 16'h0000, 1'b0, "z_st20");
      do_req(1'b0, 16'h0014, 16'h0000, 0, 16'h4321, 1'b0, "z_ld20");
      do_req(1'b0, 16'h0003, 16'h0000, 2, 16'h0000, 1'b1, "z_ld_mis");
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
